gpu_mem_coalescer: RTL and testbench

- Sits between the four gpu_warp instances and gpu_cache_L1 inside the streaming multiprocessor.
- Accepts one warp-wide memory request per handshake: per-lane byte addresses, active-lane mask and warp id.
- Merges lanes that fall in the same cache line and issues one L1 line request per unique line, with a lane mask naming the lanes served.
- Pulses a completion flag when every active lane of the warp has been covered.

---
 rtl/gpu_mem_coalescer.sv | 144 ++++++++++++++
 tb/tb_gpu_mem_coalescer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_coalescer.sv
// Warp memory coalescer: merges per-lane byte addresses into one L1 line request per unique line.
// Optional COALESCE_STATS_EN adds saturating warp/line counters on stat_warps/stat_lines.
module gpu_mem_coalescer #(
  parameter int LANES     = 32,
  parameter int ADDR_W    = 32,
  parameter int LINE_LOG2 = 5,
  parameter int WARP_ID_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*ADDR_W-1:0]     in_addr,
  input  logic [LANES-1:0]            in_mask,
  input  logic [WARP_ID_W-1:0]        in_warp,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [ADDR_W-LINE_LOG2-1:0] req_line,
  output logic [LANES-1:0]            req_mask,
  output logic [WARP_ID_W-1:0]        req_warp,
  output logic                        done,
  output logic [WARP_ID_W-1:0]        done_warp,
  output logic [15:0]                 stat_warps,
  output logic [15:0]                 stat_lines
);

  localparam int LINE_W = ADDR_W - LINE_LOG2;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_reg;
  logic [LINE_W-1:0]      line_reg [LANES];
  logic [LANES-1:0]       pending_reg;
  logic [WARP_ID_W-1:0]   warp_reg;
  logic                   done_reg;
  logic [WARP_ID_W-1:0]   done_warp_reg;

  logic                   busy;
  logic                   accept;
  logic                   xfer;
  logic [IDX_W-1:0]       leader_idx;
  logic [LINE_W-1:0]      leader_line;
  logic [LANES-1:0]       match_vec;
  logic [LANES-1:0]       pending_next;

  assign busy   = (state_reg == BUSY);
  assign accept = (state_reg == IDLE) && in_valid;
  assign xfer   = busy && req_ready;

  // Leader is the lowest pending lane; scanning downward lets the lowest index win.
  always_comb begin
    leader_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending_reg[i]) leader_idx = IDX_W'(i);
    end
  end

  assign leader_line = line_reg[leader_idx];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      // Only line bits are kept; the byte offset never influences grouping.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          line_reg[gi] <= '0;
        end else if (accept) begin
          line_reg[gi] <= in_addr[gi*ADDR_W+LINE_LOG2 +: LINE_W];
        end
      end

      assign match_vec[gi] = pending_reg[gi] && (line_reg[gi] == leader_line);
    end
  endgenerate

  assign pending_next = pending_reg & ~match_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      warp_reg      <= '0;
      done_reg      <= 1'b0;
      done_warp_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            pending_reg <= in_mask;
            warp_reg    <= in_warp;
            if (in_mask == '0) begin
              done_reg      <= 1'b1;
              done_warp_reg <= in_warp;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          if (req_ready) begin
            pending_reg <= pending_next;
            if (pending_next == '0) begin
              done_reg      <= 1'b1;
              done_warp_reg <= warp_reg;
              state_reg     <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = !busy;
  assign req_valid = busy;
  assign req_line  = busy ? leader_line : '0;
  assign req_mask  = busy ? match_vec : '0;
  assign req_warp  = busy ? warp_reg : '0;
  assign done      = done_reg;
  assign done_warp = done_warp_reg;

`ifdef COALESCE_STATS_EN
  logic [15:0] stat_warps_reg;
  logic [15:0] stat_lines_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_warps_reg <= '0;
      stat_lines_reg <= '0;
    end else begin
      if (done_reg && (stat_warps_reg != 16'hFFFF)) stat_warps_reg <= stat_warps_reg + 16'd1;
      if (xfer && (stat_lines_reg != 16'hFFFF))     stat_lines_reg <= stat_lines_reg + 16'd1;
    end
  end

  assign stat_warps = stat_warps_reg;
  assign stat_lines = stat_lines_reg;
`else
  assign stat_warps = '0;
  assign stat_lines = '0;
`endif

endmodule

// File: tb/tb_gpu_mem_coalescer.sv
// Randomized self-checking bench for gpu_mem_coalescer against a line-grouping reference model.
module tb_gpu_mem_coalescer;
  localparam int LANES = 32;
  localparam int ADDR_W = 32;
  localparam int LINE_LOG2 = 5;
  localparam int WARP_ID_W = 2;
  localparam int LINE_W = ADDR_W - LINE_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [LANES*ADDR_W-1:0] in_addr = '0;
  logic [LANES-1:0] in_mask = '0;
  logic [WARP_ID_W-1:0] in_warp = '0;
  logic req_valid;
  logic req_ready = 1'b0;
  logic [LINE_W-1:0] req_line;
  logic [LANES-1:0] req_mask;
  logic [WARP_ID_W-1:0] req_warp;
  logic done;
  logic [WARP_ID_W-1:0] done_warp;
  logic [15:0] stat_warps;
  logic [15:0] stat_lines;

  gpu_mem_coalescer #(.LANES(LANES), .ADDR_W(ADDR_W), .LINE_LOG2(LINE_LOG2), .WARP_ID_W(WARP_ID_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_mask(in_mask), .in_warp(in_warp), .req_valid(req_valid), .req_ready(req_ready),
    .req_line(req_line), .req_mask(req_mask), .req_warp(req_warp), .done(done),
    .done_warp(done_warp), .stat_warps(stat_warps), .stat_lines(stat_lines)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] addr_a [LANES];
  logic [LINE_W-1:0] exp_line [$];
  logic [LANES-1:0]  exp_mask [$];
  logic [LINE_W-1:0] obs_line [$];
  logic [LANES-1:0]  obs_mask [$];
  logic [WARP_ID_W-1:0] obs_warp [$];
  int done_seen;
  logic [WARP_ID_W-1:0] last_done_warp;
  int exp_stat_w = 0;
  int exp_stat_l = 0;

  // Reference: walk lanes in ascending order; each uncovered active lane gathers every active lane on its line.
  task automatic build_expected(input logic [LANES-1:0] mask);
    logic [LANES-1:0] covered;
    logic [LANES-1:0] m;
    logic [LINE_W-1:0] ln;
    exp_line.delete();
    exp_mask.delete();
    covered = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] && !covered[i]) begin
        ln = LINE_W'(addr_a[i] / (1 << LINE_LOG2));
        m = '0;
        for (int j = 0; j < LANES; j++)
          if (mask[j] && (LINE_W'(addr_a[j] / (1 << LINE_LOG2)) == ln)) m[j] = 1'b1;
        covered |= m;
        exp_line.push_back(ln);
        exp_mask.push_back(m);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where the first request is visible.
  task automatic send_warp(input logic [LANES-1:0] mask, input logic [WARP_ID_W-1:0] warp);
    for (int i = 0; i < LANES; i++) in_addr[i*ADDR_W +: ADDR_W] = addr_a[i];
    in_mask = mask;
    in_warp = warp;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Records transfers until the done pulse; no comparisons here.
  task automatic collect(input int ready_pct);
    obs_line.delete(); obs_mask.delete(); obs_warp.delete();
    done_seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        done_seen = 1;
        last_done_warp = done_warp;
        exp_stat_w++;
        break;
      end
      if (req_valid && ($urandom_range(99) < ready_pct)) begin
        req_ready = 1'b1;
        obs_line.push_back(req_line);
        obs_mask.push_back(req_mask);
        obs_warp.push_back(req_warp);
        exp_stat_l++;
      end else begin
        req_ready = 1'b0;
      end
      @(negedge clk);
    end
    req_ready = 1'b0;
  endtask

  task automatic compare_run(input string tag, input logic [WARP_ID_W-1:0] warp);
    n_cmp++;
    if (done_seen !== 1) begin n_err++; $display("FAIL %s done_timeout: got %0d want 1", tag, done_seen); end
    n_cmp++;
    if (last_done_warp !== warp) begin n_err++; $display("FAIL %s done_warp: got %0d want %0d", tag, last_done_warp, warp); end
    n_cmp++;
    if (obs_line.size() != exp_line.size()) begin
      n_err++; $display("FAIL %s transfer_count: got %0d want %0d", tag, obs_line.size(), exp_line.size());
    end else begin
      for (int k = 0; k < exp_line.size(); k++) begin
        n_cmp++;
        if (obs_line[k] !== exp_line[k] || obs_mask[k] !== exp_mask[k] || obs_warp[k] !== warp) begin
          n_err++;
          $display("FAIL %s xfer%0d: got line=%h mask=%h warp=%0d want line=%h mask=%h warp=%0d",
                   tag, k, obs_line[k], obs_mask[k], obs_warp[k], exp_line[k], exp_mask[k], warp);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse_width: got %b want 0", tag, done); end
    $display("%s: warp %0d, %0d transfers", tag, warp, obs_line.size());
  endtask

  task automatic check_stats(input string tag);
    logic [15:0] ew, el;
`ifdef COALESCE_STATS_EN
    ew = 16'(exp_stat_w); el = 16'(exp_stat_l);
`else
    ew = 16'd0; el = 16'd0;
`endif
    n_cmp++;
    if (stat_warps !== ew || stat_lines !== el) begin
      n_err++; $display("FAIL %s stats: got w=%0d l=%0d want w=%0d l=%0d", tag, stat_warps, stat_lines, ew, el);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || req_valid !== 1'b0 || done !== 1'b0 || req_line !== '0 ||
        req_mask !== '0 || req_warp !== '0 || done_warp !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%b line=%h mask=%h w=%0d dw=%0d want 1 0 0 0 0 0 0",
               in_ready, req_valid, done, req_line, req_mask, req_warp, done_warp);
    end
    check_stats("reset");
    rst = 1'b1;
    @(negedge clk);
    $display("reset: checked");
  endtask

  task automatic test_same_line();
    for (int i = 0; i < LANES; i++) addr_a[i] = 32'h1000 + 32'((i % 8) * 4);
    build_expected('1);
    send_warp('1, 2'd0);
    n_cmp++;
    if (req_valid !== 1'b1 || req_line !== 27'h80 || req_mask !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL same_line_first: got v=%b line=%h mask=%h want 1 80 ffffffff", req_valid, req_line, req_mask);
    end
    collect(100);
    compare_run("same_line", 2'd0);
    for (int i = 0; i < LANES; i++) addr_a[i] = 32'h1000 + 32'(4 * i);
    build_expected('1);
    send_warp('1, 2'd1);
    collect(100);
    compare_run("stride4", 2'd1);
  endtask

  task automatic test_unique_lines();
    for (int i = 0; i < LANES; i++) addr_a[i] = 32'h2000 + 32'(32 * i) + 32'($urandom_range(31));
    build_expected('1);
    send_warp('1, 2'd3);
    collect(100);
    compare_run("unique32", 2'd3);
    check_stats("unique32");
  endtask

  task automatic test_zero_mask();
    for (int i = 0; i < LANES; i++) addr_a[i] = $urandom;
    send_warp('0, 2'd2);
    n_cmp++;
    if (req_valid !== 1'b0 || done !== 1'b1 || done_warp !== 2'd2) begin
      n_err++; $display("FAIL zero_mask: got v=%b d=%b dw=%0d want 0 1 2", req_valid, done, done_warp);
    end
    exp_stat_w++;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || req_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_mask_after: got d=%b v=%b want 0 0", done, req_valid);
    end
    check_stats("zero_mask");
    $display("zero_mask: warp 2 done");
  endtask

  task automatic test_stall();
    logic [LINE_W-1:0] l0; logic [LANES-1:0] m0;
    for (int i = 0; i < LANES; i++) addr_a[i] = $urandom;
    addr_a[0] = 32'h40; addr_a[1] = 32'h60; addr_a[2] = 32'h5F; addr_a[3] = 32'h7C;
    build_expected(32'hF);
    send_warp(32'hF, 2'd1);
    l0 = req_line; m0 = req_mask;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (req_valid !== 1'b1 || req_line !== l0 || req_mask !== m0 || req_warp !== 2'd1) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b line=%h mask=%h want 1 %h %h", c, req_valid, req_line, req_mask, l0, m0);
      end
    end
    collect(100);
    compare_run("stall", 2'd1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < LANES; i++) addr_a[i] = 32'h8000 + 32'(64 * i);
    send_warp(32'h0000_00F0, 2'd2);
    req_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: got v=%b rdy=%b d=%b want 0 1 0", req_valid, in_ready, done);
    end
    req_ready = 1'b0;
    exp_stat_w = 0; exp_stat_l = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || req_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_mid_quiet%0d: got d=%b v=%b want 0 0", c, done, req_valid);
      end
    end
    check_stats("reset_mid");
    for (int i = 0; i < LANES; i++) addr_a[i] = 32'h300 + 32'($urandom_range(95));
    build_expected(32'hA5A5_0F0F);
    send_warp(32'hA5A5_0F0F, 2'd0);
    collect(70);
    compare_run("after_reset", 2'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LANES; i++) addr_a[i] = 32'h4000 + 32'($urandom_range(31));
    send_warp(32'h0000_FFFF, 2'd1);
    collect(100);
    n_cmp++;
    if (done_seen !== 1 || last_done_warp !== 2'd1 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: got done=%0d dw=%0d rdy=%b want 1 1 1", done_seen, last_done_warp, in_ready);
    end
    for (int i = 0; i < LANES; i++) addr_a[i] = 32'h6000 + 32'(($urandom_range(3)) * 32);
    build_expected(32'hFFFF_0000);
    send_warp(32'hFFFF_0000, 2'd3);
    n_cmp++;
    if (req_valid !== 1'b1 || req_warp !== 2'd3 || done !== 1'b0) begin
      n_err++; $display("FAIL b2b_second: got v=%b w=%0d d=%b want 1 3 0", req_valid, req_warp, done);
    end
    collect(100);
    compare_run("b2b_second", 2'd3);
  endtask

  task automatic test_random();
    logic [LANES-1:0] mask;
    logic [WARP_ID_W-1:0] w;
    logic [ADDR_W-1:0] base;
    for (int t = 0; t < 25; t++) begin
      base = $urandom & 32'hFFFF_F000;
      for (int i = 0; i < LANES; i++)
        addr_a[i] = base + 32'($urandom_range(7) * 32) + 32'($urandom_range(31));
      case ($urandom_range(3))
        0: mask = '1;
        1: mask = $urandom & $urandom;
        2: mask = (t % 5 == 0) ? '0 : 32'(1 << $urandom_range(31));
        default: mask = $urandom;
      endcase
      w = WARP_ID_W'($urandom_range(3));
      build_expected(mask);
      send_warp(mask, w);
      collect(60);
      compare_run("random", w);
    end
    check_stats("random");
  endtask

  initial begin
    test_reset();
    test_same_line();
    test_unique_lines();
    test_zero_mask();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
